instr_fetch_ctrl: RTL

Instruction-fetch sequencer that owns the program counter and drives the address port of the combinational instruction ROM. It captures each ROM word together with its PC into a 2-entry fetch buffer and presents them to decode over a valid/ready handshake. The block also handles branch redirects and halt detection. It sits between the ROM and the decode/execute stage in the top level.

---
 rtl/instr_fetch_ctrl_pkg.sv | 25 ++
 rtl/fetch_buffer.sv | 54 +++++
 rtl/instr_fetch_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/instr_fetch_ctrl_pkg.sv
// rtl/instr_fetch_ctrl_pkg.sv - shared fetch types, HALT encoding and FSM states
package instr_fetch_ctrl_pkg;

  localparam int PC_W = 4;

  typedef logic [PC_W-1:0] ProgramCounter;
  typedef logic [31:0]     Instruction;

  localparam Instruction HALT_INSTR = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    HALTED
  } fetch_state_t;

  typedef struct packed {
    ProgramCounter pc;
    Instruction    instr;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - 2-entry synchronous FIFO of fetch entries with flush
module fetch_buffer
  import instr_fetch_ctrl_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] push_data_i,
  input  logic               pop_i,
  input  logic               flush_i,
  output logic [1:0]         count_o,
  output logic [ENTRY_W-1:0] head_o
);

  logic [ENTRY_W-1:0] mem_q [2];
  logic               head_q, head_d;
  logic               tail_q, tail_d;
  logic [1:0]         count_q, count_d;
  logic               do_push, do_pop;

  // A push into a full buffer is legal only when the head leaves in the same cycle.
  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_push) tail_d = ~tail_q;
    if (do_pop)  head_d = ~head_q;
    if (do_push && !do_pop) count_d = count_q + 2'd1;
    if (do_pop && !do_push) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i && !rst_i) mem_q[tail_q] <= push_data_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[head_q];

endmodule

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - PC sequencer feeding a 2-entry fetch buffer to decode
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter int IW         = PC_W,
  parameter int START_ADDR = 0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  output logic [IW-1:0] rom_addr_o,
  input  logic [31:0]   rom_instr_i,
  input  logic          br_valid_i,
  input  logic [IW-1:0] br_target_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [31:0]   out_instr_o,
  output logic [IW-1:0] out_pc_o,
  output logic          halted_o
);

  localparam logic [IW-1:0] START_PC = IW'(START_ADDR);

  fetch_state_t       state_q, state_d;
  logic [IW-1:0]      pc_q, pc_d;
  logic               halted_q, halted_d;
  logic               push, pop, flush;
  logic [1:0]         buf_count;
  logic [ENTRY_W-1:0] head_raw;
  fetch_entry_t       head;
  fetch_entry_t       push_entry;

  assign out_valid_o = (buf_count != 2'd0);
  assign pop         = out_valid_o && out_ready_i;
  assign push_entry  = '{pc: pc_q, instr: rom_instr_i};
  assign head        = fetch_entry_t'(head_raw);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    push     = 1'b0;
    flush    = 1'b0;
    case (state_q)
      IDLE, HALTED: begin
        if (start_i) begin
          pc_d     = START_PC;
          flush    = 1'b1;
          halted_d = 1'b0;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        if (br_valid_i) begin
          flush = 1'b1;
          pc_d  = br_target_i;
        end else if ((buf_count != 2'd2) || pop) begin
          push = 1'b1;
          // HALT parks the PC on itself so a restart or redirect decides what comes next.
          if (rom_instr_i == HALT_INSTR) state_d = DRAIN;
          else                           pc_d    = pc_q + 1'b1;
        end
      end
      DRAIN: begin
        if (br_valid_i) begin
          flush   = 1'b1;
          pc_d    = br_target_i;
          state_d = FETCH;
        end else if (pop && (buf_count == 2'd1)) begin
          state_d  = HALTED;
          halted_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      pc_q     <= START_PC;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  fetch_buffer u_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (flush),
    .count_o     (buf_count),
    .head_o      (head_raw)
  );

  assign rom_addr_o  = pc_q;
  assign out_instr_o = head.instr;
  assign out_pc_o    = head.pc;
  assign halted_o    = halted_q;

endmodule
